// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 4-stage pipelined radix-2 DIT butterfly.
//   o1 = a + b*w, o2 = a - b*w on signed complex samples, twiddle in Q1.(TW-1).
//   Stages: S1 operand regs, S2 products, S3 rounded twiddle product, S4 sum/diff
//   with optional 1/2 scaling and range reduction into the output registers.
// Build option: define BFLY_SAT_EN to saturate overflowing components; otherwise
// they wrap. The sticky ovf flag behaves the same in both builds.
module butterfly_pipe #(
    parameter int DW    = 16,
    parameter int TW    = 16,
    parameter int SCALE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a_re,
    input  logic [DW-1:0] a_im,
    input  logic [DW-1:0] b_re,
    input  logic [DW-1:0] b_im,
    input  logic [TW-1:0] w_re,
    input  logic [TW-1:0] w_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] o1_re,
    output logic [DW-1:0] o1_im,
    output logic [DW-1:0] o2_re,
    output logic [DW-1:0] o2_im,
    output logic          ovf,
    input  logic          clr_ovf
);

    localparam int PW = DW + TW;
    localparam int SW = DW + 2;
    localparam logic signed [PW:0] RND = (PW + 1)'(2 ** (TW - 2));

`ifdef BFLY_SAT_EN
    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW - 1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW - 1){1'b0}}};
`endif

    logic en;

    logic s1_vld_q, s2_vld_q, s3_vld_q, out_vld_q, ovf_q;

    logic signed [DW-1:0] s1_a_re_q, s1_a_im_q, s1_b_re_q, s1_b_im_q;
    logic signed [TW-1:0] s1_w_re_q, s1_w_im_q;

    logic signed [DW-1:0] s2_a_re_q, s2_a_im_q;
    logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [PW-1:0] s2_p_rr_q, s2_p_ii_q, s2_p_ri_q, s2_p_ir_q;

    logic signed [PW:0]   t_re_w, t_im_w;
    logic signed [SW-1:0] t_re_d, t_im_d;
    logic signed [DW-1:0] s3_a_re_q, s3_a_im_q;
    logic signed [SW-1:0] s3_t_re_q, s3_t_im_q;

    // index order: 0 = o1_re, 1 = o1_im, 2 = o2_re, 3 = o2_im
    logic signed [SW-1:0] sum_w [4];
    logic [3:0]           ov_w;
    logic [DW-1:0]        o_d [4];
    logic [DW-1:0]        o_q [4];
    logic                 ovf_set_d;

    // Whole pipeline advances together; a held output freezes every stage.
    assign en       = out_ready | ~out_vld_q;
    assign in_ready = en;

    // S2 next state: full-width signed products.
    always_comb begin
        p_rr_d = PW'(s1_b_re_q) * PW'(s1_w_re_q);
        p_ii_d = PW'(s1_b_im_q) * PW'(s1_w_im_q);
        p_ri_d = PW'(s1_b_re_q) * PW'(s1_w_im_q);
        p_ir_d = PW'(s1_b_im_q) * PW'(s1_w_re_q);
    end

    // S3 next state: combine products, round half up, drop the twiddle fraction.
    always_comb begin
        t_re_w = (PW + 1)'(s2_p_rr_q) - (PW + 1)'(s2_p_ii_q) + RND;
        t_im_w = (PW + 1)'(s2_p_ri_q) + (PW + 1)'(s2_p_ir_q) + RND;
        t_re_d = SW'(t_re_w >>> (TW - 1));
        t_im_d = SW'(t_im_w >>> (TW - 1));
    end

    // S4 next state: sum/difference, optional halving, overflow detect and reduce.
    always_comb begin
        sum_w[0]  = SW'(s3_a_re_q) + s3_t_re_q;
        sum_w[1]  = SW'(s3_a_im_q) + s3_t_im_q;
        sum_w[2]  = SW'(s3_a_re_q) - s3_t_re_q;
        sum_w[3]  = SW'(s3_a_im_q) - s3_t_im_q;
        ov_w      = '0;
        for (int i = 0; i < 4; i++) begin
            if (SCALE != 0) begin
                sum_w[i] = (sum_w[i] + SW'(1)) >>> 1;
            end
            // In range only when the bits above the DW sign bit are all copies of it.
            ov_w[i] = ~((&sum_w[i][SW-1:DW-1]) | ~(|sum_w[i][SW-1:DW-1]));
`ifdef BFLY_SAT_EN
            if (ov_w[i]) begin
                o_d[i] = sum_w[i][SW-1] ? SAT_MIN : SAT_MAX;
            end else begin
                o_d[i] = sum_w[i][DW-1:0];
            end
`else
            o_d[i] = sum_w[i][DW-1:0];
`endif
        end
        ovf_set_d = en & s3_vld_q & (|ov_w);
    end

    // Valid bits and sticky overflow; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (en) begin
                s1_vld_q  <= in_valid;
                s2_vld_q  <= s1_vld_q;
                s3_vld_q  <= s2_vld_q;
                out_vld_q <= s3_vld_q;
            end
            if (ovf_set_d) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Datapath registers; the output only loads real samples so bubbles leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_re_q <= '0;
            s1_a_im_q <= '0;
            s1_b_re_q <= '0;
            s1_b_im_q <= '0;
            s1_w_re_q <= '0;
            s1_w_im_q <= '0;
            s2_a_re_q <= '0;
            s2_a_im_q <= '0;
            s2_p_rr_q <= '0;
            s2_p_ii_q <= '0;
            s2_p_ri_q <= '0;
            s2_p_ir_q <= '0;
            s3_a_re_q <= '0;
            s3_a_im_q <= '0;
            s3_t_re_q <= '0;
            s3_t_im_q <= '0;
            for (int i = 0; i < 4; i++) begin
                o_q[i] <= '0;
            end
        end else if (en) begin
            s1_a_re_q <= a_re;
            s1_a_im_q <= a_im;
            s1_b_re_q <= b_re;
            s1_b_im_q <= b_im;
            s1_w_re_q <= w_re;
            s1_w_im_q <= w_im;
            s2_a_re_q <= s1_a_re_q;
            s2_a_im_q <= s1_a_im_q;
            s2_p_rr_q <= p_rr_d;
            s2_p_ii_q <= p_ii_d;
            s2_p_ri_q <= p_ri_d;
            s2_p_ir_q <= p_ir_d;
            s3_a_re_q <= s2_a_re_q;
            s3_a_im_q <= s2_a_im_q;
            s3_t_re_q <= t_re_d;
            s3_t_im_q <= t_im_d;
            if (s3_vld_q) begin
                for (int i = 0; i < 4; i++) begin
                    o_q[i] <= o_d[i];
                end
            end
        end
    end

    assign out_valid = out_vld_q;
    assign ovf       = ovf_q;
    assign o1_re     = o_q[0];
    assign o1_im     = o_q[1];
    assign o2_re     = o_q[2];
    assign o2_im     = o_q[3];

endmodule
